// File: rtl/armleocpu_tlb_unit.sv
// Direct-mapped TLB: VPN[19:0] -> PPN[21:0] plus Sv32 access tag, registered lookup result.
// Handshake: resolve is a one-cycle request; done pulses exactly one cycle later with miss/phys_r/accesstag_r.
module armleocpu_tlb_unit #(
    parameter int ENTRIES_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [19:0] virtual_address,
    input  logic        invalidate,
    input  logic        resolve,
    output logic        miss,
    output logic        done,
    output logic [7:0]  accesstag_r,
    output logic [21:0] phys_r,
    input  logic        write,
    input  logic [19:0] virtual_address_w,
    input  logic [7:0]  accesstag_w,
    input  logic [21:0] phys_w
);

    localparam int ENTRIES = 1 << ENTRIES_W;
    localparam int VTAG_W  = 20 - ENTRIES_W;

    logic [ENTRIES-1:0] valid;
    logic [VTAG_W-1:0]  vtag_mem [ENTRIES];
    logic [7:0]         tag_mem  [ENTRIES];
    logic [21:0]        ppn_mem  [ENTRIES];

    logic [ENTRIES_W-1:0] rd_idx;
    logic [VTAG_W-1:0]    rd_vtag;
    logic [ENTRIES_W-1:0] wr_idx;
    logic [VTAG_W-1:0]    wr_vtag;
    logic                 hit;

    assign rd_idx  = virtual_address[ENTRIES_W-1:0];
    assign rd_vtag = virtual_address[19:ENTRIES_W];
    assign wr_idx  = virtual_address_w[ENTRIES_W-1:0];
    assign wr_vtag = virtual_address_w[19:ENTRIES_W];

    // Reads use the pre-edge arrays, so a same-cycle write is only visible to later lookups.
    assign hit = valid[rd_idx] && (vtag_mem[rd_idx] == rd_vtag);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (invalidate) begin
            valid <= '0;
        end else if (write) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Payload needs no reset: it is never observed unless the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (write) begin
            vtag_mem[wr_idx] <= wr_vtag;
            tag_mem[wr_idx]  <= accesstag_w;
            ppn_mem[wr_idx]  <= phys_w;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done        <= 1'b0;
            miss        <= 1'b0;
            phys_r      <= '0;
            accesstag_r <= '0;
        end else begin
            done <= resolve;
            miss <= 1'b0;
            if (resolve) begin
                if (!enable) begin
                    phys_r      <= {2'b00, virtual_address};
                    accesstag_r <= 8'hCF;
                end else if (hit && !invalidate) begin
                    phys_r      <= ppn_mem[rd_idx];
                    accesstag_r <= tag_mem[rd_idx];
                end else begin
                    miss <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_armleocpu_tlb_unit.sv
// Scoreboard bench for armleocpu_tlb_unit: directed scenarios plus random traffic against a slot model.
module tb_armleocpu_tlb_unit;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [19:0] virtual_address;
  logic        invalidate;
  logic        resolve;
  logic        miss;
  logic        done;
  logic [7:0]  accesstag_r;
  logic [21:0] phys_r;
  logic        write;
  logic [19:0] virtual_address_w;
  logic [7:0]  accesstag_w;
  logic [21:0] phys_w;

  armleocpu_tlb_unit #(.ENTRIES_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .virtual_address(virtual_address),
    .invalidate(invalidate), .resolve(resolve), .miss(miss), .done(done),
    .accesstag_r(accesstag_r), .phys_r(phys_r), .write(write),
    .virtual_address_w(virtual_address_w), .accesstag_w(accesstag_w), .phys_w(phys_w)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // expected word per cycle: {done, miss, accesstag[7:0], ppn[21:0]}
  logic [31:0] exp_q[$];

  // reference model: 16 slots remembering the full VPN that owns each slot
  bit          m_valid [16];
  logic [19:0] m_vpn   [16];
  logic [7:0]  m_tag   [16];
  logic [21:0] m_ppn   [16];
  logic [7:0]  m_out_tag;
  logic [21:0] m_out_ppn;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  // driver: one clock cycle of stimulus; expectation is queued once the edge consumes it
  task automatic drive(input bit res, input bit en, input logic [19:0] va,
                       input bit wr, input logic [19:0] vaw, input logic [7:0] tw,
                       input logic [21:0] pw, input bit inv);
    logic [31:0] e;
    int slot;
    resolve = res; enable = en; virtual_address = va;
    write = wr; virtual_address_w = vaw; accesstag_w = tw; phys_w = pw;
    invalidate = inv;
    slot = int'(va) % 16;
    e = '0;
    if (res) begin
      e[31] = 1'b1;
      if (!en) begin
        m_out_ppn = {2'b00, va};
        m_out_tag = 8'hCF;
      end else if (!inv && m_valid[slot] && m_vpn[slot] == va) begin
        m_out_ppn = m_ppn[slot];
        m_out_tag = m_tag[slot];
      end else begin
        e[30] = 1'b1;
      end
    end
    e[29:22] = m_out_tag;
    e[21:0]  = m_out_ppn;
    if (inv) begin
      model_clear();
    end else if (wr) begin
      slot = int'(vaw) % 16;
      m_valid[slot] = 1'b1;
      m_vpn[slot] = vaw;
      m_tag[slot] = tw;
      m_ppn[slot] = pw;
    end
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 20'h0, 0, 20'h0, 8'h0, 22'h0, 0);
  endtask

  task automatic lookup(input bit en, input logic [19:0] va);
    drive(1, en, va, 0, 20'h0, 8'h0, 22'h0, 0);
  endtask

  task automatic fill(input logic [19:0] vaw, input logic [7:0] tw, input logic [21:0] pw);
    drive(0, 0, 20'h0, 1, vaw, tw, pw, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    resolve = 0; write = 0; invalidate = 0; enable = 0;
    #1;
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_miss", {31'b0, miss}, 32'd0);
    check("reset_phys", {10'b0, phys_r}, 32'd0);
    check("reset_tag", {24'b0, accesstag_r}, 32'd0);
    exp_q.delete();
    model_clear();
    m_out_ppn = '0;
    m_out_tag = '0;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // scoreboard monitor: samples on the falling edge, away from the active edge
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("done", {31'b0, done}, {31'b0, e[31]});
          check("miss", {31'b0, miss}, {31'b0, e[30]});
          if (done && !miss) begin
            check("phys_r", {10'b0, phys_r}, {10'b0, e[21:0]});
            check("accesstag_r", {24'b0, accesstag_r}, {24'b0, e[29:22]});
          end else begin
            check("phys_hold", {10'b0, phys_r}, {10'b0, e[21:0]});
            check("tag_hold", {24'b0, accesstag_r}, {24'b0, e[29:22]});
          end
        end else if (done) begin
          check("unexpected_done", {31'b0, done}, 32'd0);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    enable = 0; virtual_address = '0; invalidate = 0; resolve = 0;
    write = 0; virtual_address_w = '0; accesstag_w = '0; phys_w = '0;
    m_out_ppn = '0; m_out_tag = '0;
    model_clear();
    @(posedge clk);
    #1;
    do_reset();

    // pass-through, then idle
    lookup(0, 20'h12345);
    idle();
    // empty TLB miss, then fill and hit
    lookup(1, 20'h00010);
    fill(20'h00010, 8'hCF, 22'h3ABCD);
    lookup(1, 20'h00010);
    idle();
    // aliasing on index 0
    fill(20'h00010, 8'h0F, 22'h000001);
    fill(20'h00020, 8'h1F, 22'h000002);
    lookup(1, 20'h00010);
    lookup(1, 20'h00020);
    // fill all, invalidate, all miss
    for (int i = 0; i < 16; i++) fill(20'h00100 + 20'(i), 8'(i), 22'h00100 + 22'(i));
    lookup(1, 20'h00105);
    drive(0, 0, 20'h0, 0, 20'h0, 8'h0, 22'h0, 1);
    for (int i = 0; i < 16; i++) lookup(1, 20'h00100 + 20'(i));
    // invalidate together with write
    for (int i = 0; i < 16; i++) fill(20'h00200 + 20'(i), 8'hC3, 22'h00200 + 22'(i));
    drive(0, 0, 20'h0, 1, 20'h00305, 8'hFF, 22'h3FFFF, 1);
    lookup(1, 20'h00305);
    for (int i = 0; i < 16; i++) lookup(1, 20'h00200 + 20'(i));
    // resolve + invalidate with pass-through and with translation
    fill(20'h00044, 8'hCB, 22'h12121);
    drive(1, 1, 20'h00044, 0, 20'h0, 8'h0, 22'h0, 1);
    drive(1, 0, 20'h00044, 0, 20'h0, 8'h0, 22'h0, 1);
    // resolve and write same VPN: read-before-write
    drive(1, 1, 20'h00033, 1, 20'h00033, 8'hDB, 22'h2AAAA, 0);
    lookup(1, 20'h00033);
    // back-to-back mixed
    lookup(0, 20'hFFFFF);
    lookup(1, 20'h00033);
    lookup(1, 20'h00034);

    // random traffic on a small VPN pool so hits and aliasing are frequent
    for (int n = 0; n < 400; n++) begin
      logic [19:0] va, vaw;
      va  = 20'($urandom_range(0, 2) * 16 + $urandom_range(0, 15));
      vaw = 20'($urandom_range(0, 2) * 16 + $urandom_range(0, 15));
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, va,
            $urandom_range(0, 2) == 0, vaw, 8'($urandom), 22'($urandom),
            $urandom_range(0, 30) == 0);
    end

    // reset with a pending result, then a previously written VPN must miss
    fill(20'h00777, 8'hCF, 22'h07777);
    lookup(1, 20'h00777);
    do_reset();
    lookup(1, 20'h00777);
    idle();
    idle();

    for (int t = 0; t < 20 && exp_q.size() > 0; t++) @(negedge clk);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
